// File: rtl/lat_histogram_collector.sv
// Latency histogram collector: bins per-cycle latency samples into on-chip RAM and tracks min/max/count.
// Define LAT_HIST_SUM_EN to add the 48-bit wrapping lat_sum accumulator (otherwise lat_sum reads 0).
module lat_histogram_collector #(
    parameter int LAT_WIDTH = 16,
    parameter int N_BINS    = 64,
    parameter int BIN_SHIFT = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 hbm_clk,
    input  logic                 hbm_rstn,
    input  logic                 clear,
    input  logic                 lat_timer_valid,
    input  logic [LAT_WIDTH-1:0] lat_timer,
    input  logic [7:0]           rd_bin_idx,
    output logic [CNT_WIDTH-1:0] rd_bin_cnt,
    output logic [CNT_WIDTH-1:0] sample_cnt,
    output logic [LAT_WIDTH-1:0] lat_min,
    output logic [LAT_WIDTH-1:0] lat_max,
    output logic [47:0]          lat_sum,
    output logic                 clear_busy,
    output logic                 cnt_sat
);
    localparam int IDX_W = $clog2(N_BINS);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       sweep_idx;
    logic                   accept;
    logic [LAT_WIDTH-1:0]   lat_shr;
    logic [IDX_W-1:0]       sample_bin;

    logic                   p0_valid, p1_valid, fwd_valid;
    logic [IDX_W-1:0]       p0_bin, p1_bin, fwd_bin;
    logic [CNT_WIDTH-1:0]   p1_data, fwd_data, bin_base, bin_inc;
    logic                   bin_full;

    logic                   wr_en;
    logic [IDX_W-1:0]       wr_bin;
    logic [CNT_WIDTH-1:0]   wr_data;
    logic [CNT_WIDTH-1:0]   bin_ram [N_BINS];
    logic [7:0]             rd_idx_q;

    assign accept     = lat_timer_valid && (state == S_RUN) && !clear;
    assign lat_shr    = lat_timer >> BIN_SHIFT;
    assign sample_bin = (lat_shr > LAT_WIDTH'(N_BINS - 1)) ? IDX_W'(N_BINS - 1) : lat_shr[IDX_W-1:0];

    always_ff @(posedge hbm_clk or negedge hbm_rstn) begin
        if (!hbm_rstn) state <= S_CLEAR;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (!clear && sweep_idx == IDX_W'(N_BINS - 1)) state_nxt = S_RUN;
            S_RUN:   if (clear) state_nxt = S_CLEAR;
            default: state_nxt = S_CLEAR;
        endcase
    end

    // The sweep owns the RAM write port while clearing; otherwise P2 writes back.
    always_comb begin
        clear_busy = 1'b0;
        wr_en      = p1_valid;
        wr_bin     = p1_bin;
        wr_data    = bin_inc;
        if (state == S_CLEAR) begin
            clear_busy = 1'b1;
            wr_en      = 1'b1;
            wr_bin     = sweep_idx;
            wr_data    = '0;
        end
    end

    always_ff @(posedge hbm_clk or negedge hbm_rstn) begin
        if (!hbm_rstn)                           sweep_idx <= '0;
        else if (clear || state != S_CLEAR)      sweep_idx <= '0;
        else                                     sweep_idx <= sweep_idx + IDX_W'(1);
    end

    // P1 reads miss only the write landing on the same edge; fwd_* holds that write.
    assign bin_base = (fwd_valid && fwd_bin == p1_bin) ? fwd_data : p1_data;
    assign bin_full = (bin_base == CNT_MAX);
    assign bin_inc  = bin_full ? bin_base : bin_base + CNT_WIDTH'(1);

    always_ff @(posedge hbm_clk or negedge hbm_rstn) begin
        if (!hbm_rstn) begin
            p0_valid  <= 1'b0;
            p0_bin    <= '0;
            p1_valid  <= 1'b0;
            p1_bin    <= '0;
            fwd_valid <= 1'b0;
            fwd_bin   <= '0;
            fwd_data  <= '0;
        end else begin
            p0_valid  <= accept;
            p0_bin    <= sample_bin;
            p1_valid  <= p0_valid && !clear;
            p1_bin    <= p0_bin;
            fwd_valid <= p1_valid && !clear;
            fwd_bin   <= p1_bin;
            fwd_data  <= bin_inc;
        end
    end

    // NOTE: the bin RAM and its read register carry no reset; the CLEAR sweep zeroes the contents, which keeps it mappable onto RAM primitives.
    always_ff @(posedge hbm_clk) begin
        if (wr_en) bin_ram[wr_bin] <= wr_data;
        p1_data <= bin_ram[p0_bin];
    end

    always_ff @(posedge hbm_clk or negedge hbm_rstn) begin
        if (!hbm_rstn) begin
            rd_idx_q   <= '0;
            rd_bin_cnt <= '0;
        end else begin
            rd_idx_q   <= rd_bin_idx;
            rd_bin_cnt <= (int'(rd_idx_q) >= N_BINS) ? '0 : bin_ram[rd_idx_q[IDX_W-1:0]];
        end
    end

    always_ff @(posedge hbm_clk or negedge hbm_rstn) begin
        if (!hbm_rstn) begin
            sample_cnt <= '0;
            lat_min    <= '1;
            lat_max    <= '0;
            cnt_sat    <= 1'b0;
        end else if (clear) begin
            sample_cnt <= '0;
            lat_min    <= '1;
            lat_max    <= '0;
            cnt_sat    <= 1'b0;
        end else begin
            if (accept) begin
                if (sample_cnt == CNT_MAX) cnt_sat <= 1'b1;
                else                       sample_cnt <= sample_cnt + CNT_WIDTH'(1);
                if (lat_timer < lat_min) lat_min <= lat_timer;
                if (lat_timer > lat_max) lat_max <= lat_timer;
            end
            if (p1_valid && bin_full) cnt_sat <= 1'b1;
        end
    end

`ifdef LAT_HIST_SUM_EN
    logic [47:0] sum_q;

    always_ff @(posedge hbm_clk or negedge hbm_rstn) begin
        if (!hbm_rstn)   sum_q <= '0;
        else if (clear)  sum_q <= '0;
        else if (accept) sum_q <= sum_q + 48'(lat_timer);
    end

    assign lat_sum = sum_q;
`else
    assign lat_sum = '0;
`endif

endmodule
